my_lsu: RTL and testbench
=========================

Name: my_lsu

Overview:
- Load/store unit directly downstream of my_datapath.
- Consumes the ALU_out address and Data_out store data, and drives a handshaked data-memory bus with byte-lane masks.
- Returns the aligned, sign/zero-extended load word that feeds Data_in.
- Stalls the core while an access is outstanding; reports misaligned, illegal-width and bus-timeout faults.

Parameters:
- TIMEOUT, 255: max cycles in ACCESS waiting for mem_ready before a bus fault; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+2): width of the wait counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core requests a memory access this instruction
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address (ALU_out)
- req_wdata  in  32  store data (Data_out)
- stall  out  1  core must hold PC/inst while high
- load_data  out  32  extended load result (to Data_in)
- load_valid  out  1  one-cycle pulse when load_data updates
- fault_valid  out  1  one-cycle fault pulse
- fault_code  out  2  01 misaligned, 10 bus timeout, 11 illegal width; 00 when no fault
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte enables; 0000 on reads
- mem_rdata  in  32  read word, valid when mem_ready=1
- mem_ready  in  1  bus completes access

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; mem_req, mem_we, stall, load_valid, fault_valid = 0; mem_addr, mem_wdata, load_data = 0; mem_wmask = 0; fault_code = 00; wait counter = 0. mem_req drops immediately, even mid-access.
- States: IDLE, ACCESS, DONE, FAULT.
- stall (combinational) = (IDLE && req_valid) || ACCESS. It is 0 in DONE and FAULT; the core advances on the edge leaving those states.
- IDLE, req_valid=1:
  - Latch we, funct3 and addr[1:0].
  - Illegal funct3 (011/110/111) → FAULT, code 11.
  - Misaligned (h with addr[0]=1, or w with addr[1:0]≠00) → FAULT, code 01.
  - Otherwise → ACCESS, with mem_req=1 and mem_addr/mem_we/mem_wdata/mem_wmask registered on the same edge.
- IDLE, req_valid=0: remain in IDLE; all bus outputs 0.
- Store lanes:
  - b: wdata = {4{wdata[7:0]}}, mask = 0001<<addr[1:0].
  - h: wdata = {2{wdata[15:0]}}, mask = 0011<<{addr[1],1'b0}.
  - w: wdata = wdata, mask = 1111.
- ACCESS:
  - Bus outputs are held stable until mem_ready is sampled high.
  - Counter increments each cycle without mem_ready.
  - mem_ready=1 → DONE. On that edge, for a load, load_data = extract(mem_rdata):
    - Byte = rdata[8*a+7:8*a].
    - Half = rdata[16*a[1]+15:16*a[1]].
    - Sign-extend for b/h, zero-extend for bu/hu.
  - mem_req and mem_wmask clear on the same edge.
  - Counter reaching TIMEOUT without ready (TIMEOUT>0) → FAULT, code 10; mem_req clears.
  - req_valid/req_* changes during ACCESS are ignored (latched copy used).
- DONE: load_valid=1 only for loads; one cycle, then → IDLE.
- FAULT: fault_valid=1 and fault_code valid for one cycle; no memory write occurs; load_data is unchanged; → IDLE. fault_code returns to 00.
- load_data holds its last value between loads; stores never modify it.
- Minimum access latency: 3 cycles (IDLE→ACCESS→DONE) with zero-wait memory. Back-to-back requests are accepted on the cycle after DONE/FAULT.
- mem_ready while not in ACCESS is ignored.
- Counter resets to 0 on every ACCESS entry.

Test Plan:
- lw addr=0x100, mem_ready after 2 wait cycles with rdata=0xDEADBEEF → mem_addr=0x100, mask 0000, stall high for 4 cycles, load_valid pulse, load_data=0xDEADBEEF.
- lb addr=0x103 and lbu addr=0x103, rdata=0x80FF0011 → load_data=0xFFFFFF80 and 0x00000080 respectively.
- sh addr=0x22, wdata=0x1234ABCD → mem_addr=0x20, mem_wdata=0xABCDABCD, mask 1100, mem_we=1; load_data unchanged.
- lw addr=0x102 → no mem_req ever asserted, fault_valid pulse with code 01, stall high exactly 1 cycle. Then funct3=011 → code 11.
- TIMEOUT=4, mem_ready held 0 → after 4 ACCESS cycles, mem_req drops, fault code 10; next request proceeds normally.
- rst driven low mid-ACCESS between clock edges → mem_req, stall and all outputs 0 immediately; after release, sb addr=0x5 completes with mask 0010.

Source files
------------

// File: rtl/my_lsu.sv
// my_lsu: load/store unit between the datapath and a handshaked data-memory bus.
// Steers store bytes onto lanes, extends load data, and flags alignment, width and timeout faults.
module my_lsu #(
    parameter int  TIMEOUT = 255,
    localparam int CNT_W   = $clog2(TIMEOUT + 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault_valid,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               lat_we;
    logic [2:0]         lat_f3;
    logic [1:0]         lat_off;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timed_out;
    logic               bad_width;
    logic               bad_align;
    logic [31:0]        st_wdata;
    logic [3:0]         st_mask;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ext_data;

    // Request decode: width legality, alignment and store lane steering.
    always_comb begin
        bad_width = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        bad_align = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        st_wdata  = req_wdata;
        st_mask   = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_mask  = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_mask  = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                st_wdata = req_wdata;
                st_mask  = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the offset and width captured at request time.
    always_comb begin
        rd_byte  = mem_rdata[{lat_off, 3'b000} +: 8];
        rd_half  = mem_rdata[{lat_off[1], 4'b0000} +: 16];
        ext_data = mem_rdata;
        case (lat_f3)
            3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ext_data = {24'd0, rd_byte};
            3'b101:  ext_data = {16'd0, rd_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        cnt_inc   = wait_cnt + 1'b1;
        timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) state_next = (bad_width || bad_align) ? FAULT : ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ready)      state_next = DONE;
                else if (timed_out) state_next = FAULT;
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are registered on ACCESS entry and cleared on the edge that leaves ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we      <= 1'b0;
            lat_f3      <= 3'b000;
            lat_off     <= 2'b00;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wmask   <= 4'b0000;
            load_data   <= 32'd0;
            load_valid  <= 1'b0;
            fault_valid <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            load_valid  <= 1'b0;
            fault_valid <= 1'b0;
            fault_code  <= 2'b00;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_f3   <= req_funct3;
                        lat_off  <= req_addr[1:0];
                        wait_cnt <= '0;
                        if (bad_width) begin
                            fault_valid <= 1'b1;
                            fault_code  <= 2'b11;
                        end else if (bad_align) begin
                            fault_valid <= 1'b1;
                            fault_code  <= 2'b01;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_we ? st_wdata : 32'd0;
                            mem_wmask <= req_we ? st_mask : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready || timed_out) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wmask <= 4'b0000;
                    end
                    if (mem_ready) begin
                        if (!lat_we) begin
                            load_data  <= ext_data;
                            load_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        fault_valid <= 1'b1;
                        fault_code  <= 2'b10;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_lsu.sv
// Scoreboard bench for my_lsu: a driver pushes expected bus/response/stall items,
// an independent negedge monitor pops and compares them as the DUT presents them.
module tb_my_lsu;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } bus_t;

    typedef struct {
        bit          is_fault;
        logic [31:0] val;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault_valid;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int passes = 0;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    stall_q[$];
    logic [31:0] model_load = 32'd0;

    my_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .fault_valid(fault_valid), .fault_code(fault_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference load result: pick the addressed bytes, then extend to 32 bits.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        int          size;
        logic [31:0] v;
        logic [31:0] keep;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        v    = rdata >> (8 * int'(off));
        if (size < 4) begin
            keep = 32'((64'd1 << (8 * size)) - 64'd1);
            v    = v & keep;
            if (!f3[2] && v[8*size-1]) v = v | ~keep;
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits, input logic [31:0] rdata);
        int    size;
        int    off;
        bit    bad_width;
        bit    bad_align;
        bit    to;
        bit    access;
        int    n_access;
        bus_t  b;
        resp_t r;
        size      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off       = int'(addr[1:0]);
        bad_width = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        bad_align = (off % size) != 0;
        to        = waits >= TO;
        access    = !bad_width && !bad_align;
        if (bad_width) begin
            r.is_fault = 1'b1; r.val = 32'd3;
            resp_q.push_back(r);
            stall_q.push_back(1);
        end else if (bad_align) begin
            r.is_fault = 1'b1; r.val = 32'd1;
            resp_q.push_back(r);
            stall_q.push_back(1);
        end else begin
            b.addr  = addr & ~32'h3;
            b.we    = we;
            b.wdata = 32'd0;
            b.mask  = 4'b0000;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    b.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
                    if (i >= off && i < off + size) b.mask[i] = 1'b1;
                end
            end
            bus_q.push_back(b);
            if (to) begin
                r.is_fault = 1'b1; r.val = 32'd2;
                resp_q.push_back(r);
                stall_q.push_back(1 + TO);
            end else begin
                stall_q.push_back(2 + waits);
                if (!we) begin
                    model_load = extend(f3, addr[1:0], rdata);
                    r.is_fault = 1'b0; r.val = model_load;
                    resp_q.push_back(r);
                end
            end
        end

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid  = access ? 1'($urandom) : 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (access) begin
            n_access = to ? TO : waits + 1;
            for (int c = 0; c < n_access; c++) begin
                mem_ready = !to && (c == waits);
                mem_rdata = mem_ready ? rdata : $urandom;
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            req_valid = 1'b0;
        end
        @(posedge clk); #1;
        checkOutput("load_hold", load_data, model_load);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    bit          prev_req = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] held_wdata;
    logic [3:0]  held_mask;
    int          run = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
            run      = 0;
        end else begin
            if (mem_req && !prev_req) begin
                if (bus_q.size() == 0) checkOutput("bus_q_avail", 32'(bus_q.size()), 32'd1);
                else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    checkOutput("mem_addr", mem_addr, b.addr);
                    checkOutput("mem_we", 32'(mem_we), 32'(b.we));
                    checkOutput("mem_wmask", 32'(mem_wmask), 32'(b.mask));
                    if (b.we) checkOutput("mem_wdata", mem_wdata, b.wdata);
                end
            end else if (mem_req) begin
                checkOutput("hold_addr", mem_addr, held_addr);
                checkOutput("hold_wdata", mem_wdata, held_wdata);
                checkOutput("hold_mask", 32'(mem_wmask), 32'(held_mask));
            end else begin
                checkOutput("idle_mask", 32'(mem_wmask), 32'd0);
            end
            prev_req   = mem_req;
            held_addr  = mem_addr;
            held_wdata = mem_wdata;
            held_mask  = mem_wmask;

            if (load_valid || fault_valid) begin
                checkOutput("req_dropped", 32'(mem_req), 32'd0);
                if (resp_q.size() == 0) checkOutput("resp_q_avail", 32'(resp_q.size()), 32'd1);
                else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    checkOutput("resp_kind", 32'(fault_valid), 32'(r.is_fault));
                    if (r.is_fault) checkOutput("fault_code", 32'(fault_code), r.val);
                    else            checkOutput("load_data", load_data, r.val);
                end
            end
            if (!fault_valid) checkOutput("code_idle", 32'(fault_code), 32'd0);

            if (stall) run++;
            else if (run > 0) begin
                if (stall_q.size() == 0) checkOutput("stall_q_avail", 32'(stall_q.size()), 32'd1);
                else checkOutput("stall_cycles", 32'(run), 32'(stall_q.pop_front()));
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_code", 32'(fault_code), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 2, 32'hDEADBEEF);
        checkOutput("lw_direct", load_data, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF0011);
        checkOutput("lb_direct", load_data, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h80FF0011);
        checkOutput("lbu_direct", load_data, 32'h00000080);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 0, 32'd0);
        checkOutput("sh_keeps_load", load_data, 32'h00000080);
        applyStimulus(1'b0, 3'b010, 32'h102, 32'd0, 0, 32'd0);
        applyStimulus(1'b0, 3'b011, 32'h100, 32'd0, 0, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h200, 32'd0, 50, 32'd0);
        applyStimulus(1'b0, 3'b101, 32'h202, 32'd0, 3, 32'h9ABC5678);
        checkOutput("lhu_after_timeout", load_data, 32'h00009ABC);

        for (int n = 0; n < 200; n++) begin
            int r;
            int waits;
            r     = int'($urandom_range(0, 7));
            waits = (r == 7) ? 20 : int'($urandom_range(0, 3));
            applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, waits, $urandom);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
                @(posedge clk); #1;
            end
        end

        // Reset asserted between edges while a load is outstanding.
        begin
            bus_t b;
            b.addr = 32'h40; b.we = 1'b0; b.wdata = 32'd0; b.mask = 4'b0000;
            bus_q.push_back(b);
            mem_ready = 1'b0;
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(posedge clk); #3;
            rst = 1'b0;
            #1;
            checkOutput("midrst_req", 32'(mem_req), 32'd0);
            checkOutput("midrst_stall", 32'(stall), 32'd0);
            checkOutput("midrst_addr", mem_addr, 32'd0);
            checkOutput("midrst_load", load_data, 32'd0);
            model_load = 32'd0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
        end
        applyStimulus(1'b1, 3'b000, 32'h5, 32'h000000A5, 1, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("bus_q_drain", 32'(bus_q.size()), 32'd0);
        checkOutput("resp_q_drain", 32'(resp_q.size()), 32'd0);
        checkOutput("stall_q_drain", 32'(stall_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
